// File: rtl/led_bar_sequencer_if.sv
// Signal bundle between the button/mode controls and the LED bar sequencer.
// Carries dim_level only when LED_BAR_PWM_DIM_EN is defined.
interface led_bar_sequencer_if #(
  parameter int unsigned LED_COUNT = 5,
  parameter int unsigned PHASE_W   = $clog2(2 * LED_COUNT)
);
  logic                 btn_next_led_debounded;
  logic                 auto_en;
  logic [1:0]           pattern_sel;
`ifdef LED_BAR_PWM_DIM_EN
  logic [3:0]           dim_level;
`endif
  logic [PHASE_W-1:0]   phase;
  logic [LED_COUNT-1:0] led_output;

  modport master (
    output btn_next_led_debounded,
    output auto_en,
    output pattern_sel,
`ifdef LED_BAR_PWM_DIM_EN
    output dim_level,
`endif
    input  phase,
    input  led_output
  );

  modport slave (
    input  btn_next_led_debounded,
    input  auto_en,
    input  pattern_sel,
`ifdef LED_BAR_PWM_DIM_EN
    input  dim_level,
`endif
    output phase,
    output led_output
  );
endinterface

// File: rtl/led_bar_sequencer.sv
// LED bar sequencer: 2*LED_COUNT-step phase driven by button or prescaler tick,
// decoded into FILL/DOT/BLINK patterns. LED_BAR_PWM_DIM_EN adds PWM dimming.
module led_bar_sequencer #(
  parameter int unsigned LED_COUNT = 5,
  parameter int unsigned TICK_DIV  = 12500000,
  parameter int unsigned PHASE_W   = $clog2(2 * LED_COUNT),
  parameter int unsigned PRESC_W   = $clog2(TICK_DIV)
) (
  input logic                clk,
  input logic                sync_reset,
  led_bar_sequencer_if.slave bus
);
  localparam int unsigned PW1 = PHASE_W + 1;
  localparam logic [PHASE_W-1:0] PhaseLast = PHASE_W'(2 * LED_COUNT - 1);
  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(TICK_DIV - 1);
  localparam logic [PW1-1:0]     NumW      = PW1'(LED_COUNT);
  localparam logic [PW1-1:0]     TwoNW     = PW1'(2 * LED_COUNT);

  logic [PHASE_W-1:0]   phase_q;
  logic [PRESC_W-1:0]   presc_q;
  logic [1:0]           pattern_q;
  logic [LED_COUNT-1:0] led_q;
  logic [LED_COUNT-1:0] decoded;
  logic [LED_COUNT-1:0] led_d;
  logic [PRESC_W-1:0]   presc_d;
  logic [PW1-1:0]       p_ext;
  logic [PW1-1:0]       level;
  logic [PW1-1:0]       idx;
  logic                 change;
  logic                 tick;
  logic                 step;

`ifdef LED_BAR_PWM_DIM_EN
  logic [3:0] pwm_cnt_q;
`endif

  always_comb begin
    change  = (bus.pattern_sel != pattern_q);
    tick    = bus.auto_en && (presc_q == PrescLast);
    step    = bus.auto_en ? tick : bus.btn_next_led_debounded;
    presc_d = (bus.auto_en && !tick) ? presc_q + PRESC_W'(1) : '0;
  end

  // Mirror the phase around the bar ends; widened by one bit so 2N never overflows.
  always_comb begin
    p_ext   = {1'b0, phase_q};
    level   = (p_ext <= NumW) ? p_ext : TwoNW - p_ext;
    idx     = (p_ext < NumW) ? p_ext : TwoNW - PW1'(1) - p_ext;
    decoded = '0;
    unique case (pattern_q)
      2'b00: for (int i = 0; i < LED_COUNT; i++) decoded[i] = (PW1'(i) < level);
      2'b01: for (int i = 0; i < LED_COUNT; i++) decoded[i] = (PW1'(i) == idx);
      2'b10: decoded = {LED_COUNT{phase_q[0]}};
      default: decoded = '0;
    endcase
  end

  always_comb begin
`ifdef LED_BAR_PWM_DIM_EN
    led_d = decoded & {LED_COUNT{pwm_cnt_q <= bus.dim_level}};
`else
    led_d = decoded;
`endif
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      phase_q   <= '0;
      presc_q   <= '0;
      pattern_q <= 2'b00;
      led_q     <= '0;
`ifdef LED_BAR_PWM_DIM_EN
      pwm_cnt_q <= '0;
`endif
    end else begin
      pattern_q <= bus.pattern_sel;
      led_q     <= led_d;
`ifdef LED_BAR_PWM_DIM_EN
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
`endif
      // A pattern change restarts the cycle and drops any step on the same edge.
      if (change) begin
        phase_q <= '0;
        presc_q <= '0;
      end else begin
        presc_q <= presc_d;
        if (step) phase_q <= (phase_q == PhaseLast) ? '0 : phase_q + PHASE_W'(1);
      end
    end
  end

  assign bus.phase      = phase_q;
  assign bus.led_output = led_q;
endmodule

// File: tb/tb_led_bar_sequencer.sv
// Self-checking bench for led_bar_sequencer (LED_COUNT=5, TICK_DIV=4): directed
// scenarios with literal expectations plus randomized stimulus against a model.
module tb_led_bar_sequencer;
  localparam int N  = 5;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic sync_reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  led_bar_sequencer_if #(.LED_COUNT(N)) bus ();

  led_bar_sequencer #(.LED_COUNT(N), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_phase = 0, m_presc = 0, m_pat = 0, m_led = 0;
  bit model_valid = 1'b0;

  function automatic int model_led(int p, int pat);
    int lvl, idx;
    case (pat)
      0: begin lvl = (p <= N) ? p : 2 * N - p; return (1 << lvl) - 1; end
      1: begin idx = (p < N) ? p : 2 * N - 1 - p; return 1 << idx; end
      2: return (p % 2 == 1) ? (1 << N) - 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the inputs present at the edge, then compare.
  task automatic cycle();
    int nph, npr, npa, nled;
    bit tick, stp;
    if (sync_reset) begin
      nph = 0; npr = 0; npa = 0; nled = 0;
    end else begin
      nled = model_led(m_phase, m_pat);
      tick = bus.auto_en && (m_presc == TD - 1);
      stp  = bus.auto_en ? tick : bus.btn_next_led_debounded;
      npa  = int'(bus.pattern_sel);
      if (npa != m_pat) begin
        nph = 0; npr = 0;
      end else begin
        nph = stp ? (m_phase + 1) % (2 * N) : m_phase;
        npr = bus.auto_en ? (m_presc + 1) % TD : 0;
      end
    end
    @(posedge clk);
    #1;
    if (sync_reset) model_valid = 1'b1;
    m_phase = nph; m_presc = npr; m_pat = npa; m_led = nled;
    if (model_valid) begin
      check("model_phase", 32'(bus.phase), 32'(m_phase));
      check("model_led", 32'(bus.led_output), 32'(m_led));
    end
  endtask

  task automatic do_reset(int cycles);
    sync_reset = 1'b1;
    repeat (cycles) cycle();
    sync_reset = 1'b0;
  endtask

  int fill_exp[10] = '{1, 3, 7, 15, 31, 15, 7, 3, 1, 0};
  int dot_exp[10]  = '{2, 4, 8, 16, 16, 8, 4, 2, 1, 1};

  initial begin
    bus.btn_next_led_debounded = 1'b0;
    bus.auto_en     = 1'b0;
    bus.pattern_sel = 2'b00;
`ifdef LED_BAR_PWM_DIM_EN
    bus.dim_level   = 4'd15;
`endif

    // Reset held two cycles with busy stimulus
    bus.btn_next_led_debounded = 1'b1;
    bus.pattern_sel = 2'b01;
    sync_reset = 1'b1;
    cycle();
    check("reset_phase", 32'(bus.phase), 32'd0);
    check("reset_led", 32'(bus.led_output), 32'd0);
    cycle();
    bus.btn_next_led_debounded = 1'b0;
    bus.pattern_sel = 2'b00;
    sync_reset = 1'b0;
    repeat (2) cycle();

    // Manual FILL
    for (int k = 0; k < 10; k++) begin
      bus.btn_next_led_debounded = 1'b1;
      cycle();
      bus.btn_next_led_debounded = 1'b0;
      cycle();
      check($sformatf("fill_step%0d", k), 32'(bus.led_output), 32'(fill_exp[k]));
    end
    check("fill_wrap_phase", 32'(bus.phase), 32'd0);

    // Manual DOT, back-to-back pulses
    bus.pattern_sel = 2'b01;
    cycle();
    cycle();
    for (int k = 0; k < 10; k++) begin
      bus.btn_next_led_debounded = 1'b1;
      cycle();
      check($sformatf("dot_phase%0d", k), 32'(bus.phase), 32'((k + 1) % 10));
      if (k > 0) check($sformatf("dot_step%0d", k - 1), 32'(bus.led_output), 32'(dot_exp[k - 1]));
    end
    bus.btn_next_led_debounded = 1'b0;
    cycle();
    check("dot_step9", 32'(bus.led_output), 32'(dot_exp[9]));

    // Auto mode, button toggling every cycle
    bus.pattern_sel = 2'b00;
    do_reset(1);
    bus.auto_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      bus.btn_next_led_debounded = ~bus.btn_next_led_debounded;
      cycle();
      if (c == 3) check("auto_c3", 32'(bus.phase), 32'd0);
      if (c == 4) check("auto_c4", 32'(bus.phase), 32'd1);
      if (c == 7) check("auto_c7", 32'(bus.phase), 32'd1);
      if (c == 8) check("auto_c8", 32'(bus.phase), 32'd2);
    end
    bus.btn_next_led_debounded = 1'b0;

    // Pattern change collides with a step pulse at phase 6
    bus.auto_en = 1'b0;
    do_reset(1);
    repeat (6) begin
      bus.btn_next_led_debounded = 1'b1;
      cycle();
    end
    check("chg_pre_phase", 32'(bus.phase), 32'd6);
    bus.pattern_sel = 2'b01;
    cycle();
    check("chg_phase", 32'(bus.phase), 32'd0);
    bus.btn_next_led_debounded = 1'b0;
    cycle();
    check("chg_led", 32'(bus.led_output), 32'd1);

    // Reset mid auto-run at prescaler=2, phase=3
    bus.pattern_sel = 2'b00;
    do_reset(1);
    bus.auto_en = 1'b1;
    repeat (14) cycle();
    check("mid_phase", 32'(bus.phase), 32'd3);
    sync_reset = 1'b1;
    cycle();
    check("mid_rst_phase", 32'(bus.phase), 32'd0);
    check("mid_rst_led", 32'(bus.led_output), 32'd0);
    sync_reset = 1'b0;
    repeat (3) cycle();
    check("mid_rel_c3", 32'(bus.phase), 32'd0);
    cycle();
    check("mid_rel_c4", 32'(bus.phase), 32'd1);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      sync_reset = ($urandom_range(0, 199) == 0);
      bus.btn_next_led_debounded = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) bus.auto_en = ~bus.auto_en;
      if ($urandom_range(0, 29) == 0) bus.pattern_sel = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
